// File: rtl/ex_bht_pkg.sv
// Shared types and constants for the EX-resolved branch history table.
// Branch funct codes follow the RV32 B-type funct3 encoding.
package ex_bht_pkg;

  localparam int unsigned XlenDefault = 32;

  typedef enum logic [2:0] {
    BEq  = 3'b000,
    BNe  = 3'b001,
    BLt  = 3'b100,
    BGe  = 3'b101,
    BLtu = 3'b110,
    BGeu = 3'b111
  } bxx_funct_e;

  typedef enum logic [1:0] {
    CntSnt = 2'b00,
    CntWnt = 2'b01,
    CntWt  = 2'b10,
    CntSt  = 2'b11
  } cnt_e;

  // 2-bit saturating counter step.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    res = cnt;
    if (up) begin
      if (cnt != CntSt) res = cnt + 2'd1;
    end else begin
      if (cnt != CntSnt) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ex_bht_bxx_resolve.sv
// Combinational branch condition evaluation from ALU compare flags.
// Undefined funct codes resolve as not-taken.
module ex_bht_bxx_resolve
  import ex_bht_pkg::*;
(
  input  logic [2:0] bxx_funct_i,
  input  logic       alu_zero_i,
  input  logic       alu_sign_i,
  input  logic       alu_carry_i,
  output logic       actual_o
);

  always_comb begin
    actual_o = 1'b0;
    case (bxx_funct_e'(bxx_funct_i))
      BEq:     actual_o = alu_zero_i;
      BNe:     actual_o = ~alu_zero_i;
      BLt:     actual_o = alu_sign_i;
      BGe:     actual_o = ~alu_sign_i;
      BLtu:    actual_o = alu_carry_i;
      BGeu:    actual_o = ~alu_carry_i;
      default: actual_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_bht.sv
// Dynamic branch predictor: IF lookup of 2-bit counters, EX resolve/train/flush.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module ex_bht
  import ex_bht_pkg::*;
#(
  parameter int unsigned XLEN   = XlenDefault,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned GHR_W  = 6,
  parameter int unsigned MISS_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_valid_i,
  input  logic [XLEN-1:0]   if_pc_i,
  output logic              if_take_o,
  output logic [IDX_W-1:0]  if_idx_o,
  input  logic              ex_branch_i,
  input  logic              ex_stall_i,
  input  logic [2:0]        bxx_funct_i,
  input  logic              alu_zero_i,
  input  logic              alu_sign_i,
  input  logic              alu_carry_i,
  input  logic              ex_take_i,
  input  logic [IDX_W-1:0]  ex_idx_i,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  logic [XLEN-1:0]   bxx_imm_i,
  output logic              bxx_flush_o,
  output logic              predict_fail_o,
  output logic [XLEN-1:0]   fail_addr_o,
  output logic [MISS_W-1:0] miss_cnt_o
);

  localparam int unsigned Depth = 2 ** IDX_W;

  logic [1:0]        bht_q [Depth];
  logic [IDX_W-1:0]  lookup_idx;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic              actual;
  logic              upd;

  logic unused_pc;
  assign unused_pc = ^{if_pc_i[XLEN-1:IDX_W+2], if_pc_i[1:0]};

`ifdef BHT_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;

  // History is non-speculative: only resolved branches shift in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr_q <= '0;
    end else if (upd) begin
      ghr_q <= {ghr_q[GHR_W-2:0], actual};
    end
  end

  assign lookup_idx = if_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
`else
  localparam int unsigned UnusedGhrW = GHR_W;
  assign lookup_idx = if_pc_i[IDX_W+1:2];
`endif

  ex_bht_bxx_resolve u_resolve (
    .bxx_funct_i (bxx_funct_i),
    .alu_zero_i  (alu_zero_i),
    .alu_sign_i  (alu_sign_i),
    .alu_carry_i (alu_carry_i),
    .actual_o    (actual)
  );

  assign upd            = ex_branch_i & ~ex_stall_i;
  assign predict_fail_o = upd & (actual ^ ex_take_i);
  assign bxx_flush_o    = predict_fail_o;
  assign fail_addr_o    = !predict_fail_o ? '0 :
                          actual          ? ex_pc_i + bxx_imm_i :
                                            ex_pc_i + XLEN'(4);

  // Lookup sees the pre-update counter; no write bypass.
  assign if_idx_o  = lookup_idx;
  assign if_take_o = if_valid_i & bht_q[lookup_idx][1];

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (predict_fail_o && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + MISS_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) bht_q[i] <= CntWnt;
      miss_cnt_q <= '0;
    end else begin
      if (upd) bht_q[ex_idx_i] <= cnt_next(bht_q[ex_idx_i], actual);
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_ex_bht.sv
// Directed bench for ex_bht; expectations queued at drive time, popped at sample time.
module tb_ex_bht;

  localparam int unsigned XLEN = 32;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned MISS_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_valid;
  logic [XLEN-1:0]   if_pc;
  logic              if_take;
  logic [IDX_W-1:0]  if_idx;
  logic              ex_branch, ex_stall;
  logic [2:0]        bxx_funct;
  logic              alu_zero, alu_sign, alu_carry;
  logic              ex_take;
  logic [IDX_W-1:0]  ex_idx;
  logic [XLEN-1:0]   ex_pc, bxx_imm;
  logic              bxx_flush, predict_fail;
  logic [XLEN-1:0]   fail_addr;
  logic [MISS_W-1:0] miss_cnt;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ex_bht dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .if_valid_i     (if_valid),
    .if_pc_i        (if_pc),
    .if_take_o      (if_take),
    .if_idx_o       (if_idx),
    .ex_branch_i    (ex_branch),
    .ex_stall_i     (ex_stall),
    .bxx_funct_i    (bxx_funct),
    .alu_zero_i     (alu_zero),
    .alu_sign_i     (alu_sign),
    .alu_carry_i    (alu_carry),
    .ex_take_i      (ex_take),
    .ex_idx_i       (ex_idx),
    .ex_pc_i        (ex_pc),
    .bxx_imm_i      (bxx_imm),
    .bxx_flush_o    (bxx_flush),
    .predict_fail_o (predict_fail),
    .fail_addr_o    (fail_addr),
    .miss_cnt_o     (miss_cnt)
  );

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: got %0h required an entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: got %0h required %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_take);
    if_valid = 1'b1;
    if_pc    = pc;
    push(tag, {31'd0, exp_take});
    #1;
    pop_check({31'd0, if_take});
  endtask

  task automatic check_miss(input string tag, input logic [15:0] exp);
    push(tag, {16'd0, exp});
    pop_check({16'd0, miss_cnt});
  endtask

  // Drive one EX branch, check the combinational resolve, then clock it in.
  task automatic ex_step(input string tag, input logic [2:0] f, input logic z, input logic s,
                         input logic c, input logic tk, input logic [IDX_W-1:0] idx,
                         input logic [31:0] pc, input logic [31:0] imm, input logic stall,
                         input logic exp_fail, input logic [31:0] exp_addr);
    ex_branch = 1'b1;
    ex_stall  = stall;
    bxx_funct = f;
    alu_zero  = z;
    alu_sign  = s;
    alu_carry = c;
    ex_take   = tk;
    ex_idx    = idx;
    ex_pc     = pc;
    bxx_imm   = imm;
    push({tag, "_fail"}, {31'd0, exp_fail});
    push({tag, "_flush"}, {31'd0, exp_fail});
    push({tag, "_addr"}, exp_addr);
    #1;
    pop_check({31'd0, predict_fail});
    pop_check({31'd0, bxx_flush});
    pop_check(fail_addr);
    tick();
    ex_branch = 1'b0;
    ex_stall  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    if_valid = 1'b0; if_pc = '0;
    ex_branch = 1'b0; ex_stall = 1'b0; bxx_funct = 3'b000;
    alu_zero = 1'b0; alu_sign = 1'b0; alu_carry = 1'b0;
    ex_take = 1'b0; ex_idx = '0; ex_pc = '0; bxx_imm = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    lookup("rst_take", 32'h100, 1'b0);
    check_miss("rst_miss", 16'd0);
    if_valid = 1'b0;
    if_pc = 32'h13C; // any entry; invalid lookup must not hint taken
    push("invalid_take", 32'd0);
    #1;
    pop_check({31'd0, if_take});

`ifndef BHT_GSHARE_EN
    // BEQ taken, predicted not-taken
    ex_step("beq_miss", 3'b000, 1, 0, 0, 0, 6'd0, 32'h100, 32'h20, 0, 1, 32'h120);
    check_miss("miss1", 16'd1);
    lookup("idx0_wt", 32'h100, 1'b1);

    // Four taken resolves saturate at ST; two not-taken step down to WNT
    for (int i = 0; i < 4; i++)
      ex_step("beq_tk", 3'b000, 1, 0, 0, 1, 6'd0, 32'h100, 32'h20, 0, 0, 32'h0);
    lookup("idx0_st", 32'h100, 1'b1);
    ex_step("nt1", 3'b000, 0, 0, 0, 1, 6'd0, 32'h100, 32'h20, 0, 1, 32'h104);
    lookup("idx0_wt2", 32'h100, 1'b1);
    ex_step("nt2", 3'b000, 0, 0, 0, 1, 6'd0, 32'h100, 32'h20, 0, 1, 32'h104);
    lookup("idx0_wnt", 32'h100, 1'b0);
    check_miss("miss3", 16'd3);

    // PC wrap on both redirect targets
    ex_step("bgeu_wrap", 3'b111, 0, 0, 1, 1, 6'd5, 32'hFFFF_FFFC, 32'h40, 0, 1, 32'h0);
    ex_step("bne_wrap", 3'b001, 0, 0, 0, 0, 6'd6, 32'hFFFF_FFF0, 32'h20, 0, 1, 32'h10);
    check_miss("miss5", 16'd5);
    lookup("idx6_wt", 32'h18, 1'b1);
    lookup("idx5_snt", 32'h14, 1'b0);

    // Same-cycle lookup and update of idx 7: old value visible before the edge
    if_valid = 1'b1;
    if_pc = 32'h1C;
    ex_branch = 1'b1; ex_stall = 1'b0; bxx_funct = 3'b100;
    alu_sign = 1'b1; alu_zero = 1'b0; alu_carry = 1'b0; ex_take = 1'b1; ex_idx = 6'd7;
    push("same_cyc_old", 32'd0);
    #1;
    pop_check({31'd0, if_take});
    tick();
    ex_branch = 1'b0;
    lookup("same_cyc_new", 32'h1C, 1'b1);

    // Stalled mispredict is inert; released stall re-evaluates it
    ex_step("stall", 3'b000, 1, 0, 0, 0, 6'd8, 32'h20, 32'h40, 1, 0, 32'h0);
    check_miss("stall_miss", 16'd5);
    lookup("stall_take", 32'h20, 1'b0);
    ex_step("unstall", 3'b000, 1, 0, 0, 0, 6'd8, 32'h20, 32'h40, 0, 1, 32'h60);
    check_miss("unstall_miss", 16'd6);
    lookup("unstall_take", 32'h20, 1'b1);

    // Undefined funct resolves not-taken
    ex_step("undef", 3'b010, 1, 1, 1, 1, 6'd9, 32'h300, 32'h80, 0, 1, 32'h304);
    check_miss("undef_miss", 16'd7);

    // Asynchronous reset mid-run
    #2;
    rst_n = 1'b0;
    #1;
    check_miss("async_rst_miss", 16'd0);
    lookup("async_rst_take", 32'h100, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    lookup("post_rst_idx8", 32'h20, 1'b0);
`else
    // Same PC, different history: distinct entries are trained
    if_valid = 1'b1; if_pc = 32'h100;
    push("g_idx_h0", 32'd0);
    #1;
    pop_check({26'd0, if_idx});
    ex_step("g_tk", 3'b000, 1, 0, 0, 0, 6'd0, 32'h100, 32'h20, 0, 1, 32'h120);
    if_pc = 32'h100;
    push("g_idx_h1", 32'd1);
    #1;
    pop_check({26'd0, if_idx});
    lookup("g_idx1_take", 32'h100, 1'b0);
    ex_step("g_nt", 3'b000, 0, 0, 0, 0, 6'd1, 32'h100, 32'h20, 0, 0, 32'h0);
    if_pc = 32'h100;
    push("g_idx_h2", 32'd2);
    #1;
    pop_check({26'd0, if_idx});
    lookup("g_idx0_take", 32'h108, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    if_pc = 32'h100;
    push("g_rst_idx", 32'd0);
    #1;
    pop_check({26'd0, if_idx});
    tick();
    rst_n = 1'b1;
    tick();
`endif

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1);
  end

endmodule
